// File: rtl/uart_tx_serializer.sv
// FIFO-draining 8N1 UART transmitter: pops one byte per frame and shifts it out LSB-first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_serializer #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_d, rd_en_d, busy_d;
  logic                 baud_last;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign baud_last = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx         <= tx_d;
      fifo_rd_en <= rd_en_d;
      busy       <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // bit_q counts data bits in DATA and stop bits in STOP; baud_q wraps at every bit boundary
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx;
    rd_en_d = 1'b0;
    busy_d  = busy;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: state_d = LOAD;
      LOAD: begin
        shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
        parity_d = ^fifo_data;
`endif
        tx_d    = 1'b0;
        baud_d  = '0;
        state_d = START;
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at 16 clocks per bit with a small registered-read FIFO model.
// Build with UART_TX_PARITY_EN defined to also check the parity bit.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int CPB   = 16;
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;

  logic [7:0] mem [256];
  logic [7:0] wr_ptr = '0;
  logic [7:0] rd_ptr = '0;
  logic [7:0] fifo_q = '0;
  logic [7:0] noise = '0;
  logic       noise_en = 1'b0;
  logic       fresh = 1'b0;
  int         empty_pops = 0;
  int         cyc = 0;
  int         n_total = 0;
  int         n_bad = 0;

  uart_tx_serializer #(
    .CLK_FREQ (1600),
    .BAUD_RATE(100),
    .DATA_BITS(8),
    .STOP_BITS(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // FIFO read port: data registered on the edge that samples the pop strobe
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = (noise_en && !fresh) ? noise : fifo_q;

  always @(posedge clk) begin
    fresh <= fifo_rd_en;
    if (fifo_rd_en) begin
      if (fifo_empty) empty_pops <= empty_pops + 1;
      fifo_q <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 8'd1;
    end
  end

  always @(negedge clk) if (noise_en) noise <= 8'($urandom);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic wait_start(output int l_cyc);
    for (int i = 0; i < 400 && tx !== 1'b0; i++) step();
    chk("start_seen", {31'd0, tx}, 32'd0);
    l_cyc = cyc;
  endtask

  // samples every bit at mid-period; bits[0] is the start bit
  task automatic recv(output logic [10:0] bits, output int l_cyc);
    bits = '0;
    wait_start(l_cyc);
    repeat (CPB / 2) step();
    bits[0] = tx;
    for (int k = 1; k < NB; k++) begin
      repeat (CPB) step();
      bits[k] = tx;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy !== 1'b0; i++) step();
  endtask

  initial begin
    logic [10:0] bits;
    int l0, l1, l2, p, base, lows, busys, pops;

    // reset with FIFO empty
    repeat (3) step();
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) lows++;
    end
    chk("idle_quiet", 32'(lows), 32'd0);

    // single byte 0xA5: latency, bit pattern, busy and frame length
    base = rd_ptr;
    push(8'hA5);
    for (int i = 0; i < 10 && fifo_rd_en !== 1'b1; i++) step();
    chk("pop_seen", {31'd0, fifo_rd_en}, 32'd1);
    p = cyc;
    step();
    chk("pop_pulse", {31'd0, fifo_rd_en}, 32'd0);
    chk("tx_before_start", {31'd0, tx}, 32'd1);
    step();
    chk("start_latency", {31'd0, tx}, 32'd0);
    recv(bits, l0);
`ifdef UART_TX_PARITY_EN
    chk("a5_bits", 32'(bits), 32'h52A);
`else
    chk("a5_bits", 32'(bits), 32'h34A);
`endif
    wait_idle();
    chk("busy_len", 32'(cyc - p), 32'(2 + FRAME));
    chk("frame_len", 32'(cyc - l0), 32'(FRAME));
    chk("a5_pops", 32'(rd_ptr - 8'(base)), 32'd1);

    // back-to-back frames
    base = rd_ptr;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    recv(bits, l0);
    chk("b2b_byte0", 32'(bits[8:1]), 32'h00);
    recv(bits, l1);
    chk("b2b_byte1", 32'(bits[8:1]), 32'hFF);
    chk("gap0", 32'(l1 - l0 - FRAME), 32'd3);
    recv(bits, l2);
    chk("b2b_byte2", 32'(bits[8:1]), 32'h3C);
    chk("gap1", 32'(l2 - l1 - FRAME), 32'd3);
    wait_idle();
    repeat (20) step();
    chk("b2b_pops", 32'(rd_ptr - 8'(base)), 32'd3);
    chk("empty_pops", 32'(empty_pops), 32'd0);

    // reset in the middle of data bit 3 of 0x55 (that bit is 0)
    push(8'h55);
    wait_start(l0);
    repeat (4 * CPB + CPB / 2) step();
    chk("pre_rst_tx", {31'd0, tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_tx", {31'd0, tx}, 32'd1);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    base = rd_ptr;
    lows = 0;
    busys = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    chk("post_rst_low", 32'(lows), 32'd0);
    chk("post_rst_busy", 32'(busys), 32'd0);
    pops = rd_ptr - 8'(base);
    chk("post_rst_pops", 32'(pops), 32'd0);

    // fifo_data noise outside the load cycle
    noise_en = 1'b1;
    push(8'h81);
    recv(bits, l0);
    noise_en = 1'b0;
    chk("noise_byte", 32'(bits[8:1]), 32'h81);
    chk("noise_stop", {31'd0, bits[NB-1]}, 32'd1);
    wait_idle();

    // parity sensitive bytes
    push(8'h07);
    recv(bits, l0);
    chk("byte_07", 32'(bits[8:1]), 32'h07);
`ifdef UART_TX_PARITY_EN
    chk("parity_07", {31'd0, bits[9]}, 32'd1);
`endif
    wait_idle();
    chk("frame_len_07", 32'(cyc - l0), 32'(FRAME));
    push(8'h03);
    recv(bits, l0);
    chk("byte_03", 32'(bits[8:1]), 32'h03);
`ifdef UART_TX_PARITY_EN
    chk("parity_03", {31'd0, bits[9]}, 32'd0);
`endif
    wait_idle();
    chk("final_empty_pops", 32'(empty_pops), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
